serial_subtractor_ctrl: RTL

Bit-serial multi-bit subtractor controller that computes a - b. It sequences a single 1-bit full-subtractor datapath (diff = x^y^bin; bout = (~x&y) | (~(x^y)&bin)) over WIDTH cycles, LSB first. A start/busy/done handshake makes it a small, area-cheap arithmetic unit for control paths where latency is not critical.

---
 rtl/serial_subtractor_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b: one full-subtractor cell stepped LSB-first over WIDTH cycles behind a start/busy/done handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow output.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             borrow_out,
    output logic             overflow
`else
    output logic             borrow_out
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_aSh;
    logic [WIDTH-1:0] r_bSh;
    logic [WIDTH-1:0] r_rSh;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrowOut;

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_nextR;

    assign w_x     = r_aSh[0];
    assign w_y     = r_bSh[0];
    assign w_d     = w_x ^ w_y ^ r_borrow;
    assign w_bout  = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
    assign w_nextR = {w_d, r_rSh[WIDTH-1:1]};

    // The last RUN edge hands the freshly shifted result straight to diff, so no extra cycle is spent
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_aSh       <= '0;
            r_bSh       <= '0;
            r_rSh       <= '0;
            r_cnt       <= '0;
            r_borrow    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_diff      <= '0;
            r_borrowOut <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_aSh    <= a;
                        r_bSh    <= b;
                        r_rSh    <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_rSh    <= w_nextR;
                    r_borrow <= w_bout;
                    r_aSh    <= {1'b0, r_aSh[WIDTH-1:1]};
                    r_bSh    <= {1'b0, r_bSh[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_diff      <= w_nextR;
                        r_borrowOut <= w_bout;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_aMsb;
    logic r_bMsb;
    logic r_overflow;

    // The final serial bit is the result MSB, so overflow is resolved on the same edge as diff
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aMsb     <= 1'b0;
            r_bMsb     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_aMsb <= a[WIDTH-1];
            r_bMsb <= b[WIDTH-1];
        end else if (r_state == RUN && r_cnt == LAST_CNT) begin
            r_overflow <= (r_aMsb != r_bMsb) && (w_d != r_aMsb);
        end
    end

    assign overflow = r_overflow;
`endif

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrowOut;

endmodule
